fetch_sequencer: RTL and testbench

Instruction-fetch sequencer that consumes the program-counter value and drives the instruction-memory read interface of the processor. It holds the fetch PC, issues one read per instruction over a req/ack handshake to a memory of arbitrary latency, and presents each fetched word to the decode stage over a valid/ready handshake. Branch and jump targets from execute arrive as a redirect that overrides sequential PC+4 progression, including while a read is in flight.

---
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_sequencer.sv | 102 ++++++++++
 tb/tb_fetch_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read port and decode-side handshake of the fetch sequencer.
// master = sequencer side, slave = memory/decode/execute environment.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: one req/ack read per instruction, valid/ready to decode,
// with redirects overriding sequential PC+4 even while a read is outstanding.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {StStart, StReq, StDrain, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] target;

  assign target = bus.redirect_pc & ~32'd3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StStart;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  // req_addr is only reloaded on the transition into StReq, so it is frozen for the whole
  // request (including the StDrain tail after a redirect).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    unique case (state_q)
      StStart: begin
        if (bus.redirect) pc_d = target;
        req_addr_d = pc_d;
        state_d    = StReq;
      end
      StReq: begin
        if (bus.redirect) begin
          pc_d = target;
          if (bus.imem_ack) begin
            req_addr_d = target;
          end else begin
            state_d = StDrain;
          end
        end else if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = req_addr_q;
          pc_d       = req_addr_q + 32'd4;
          valid_d    = 1'b1;
          state_d    = StHold;
        end
      end
      StDrain: begin
        if (bus.redirect) pc_d = target;
        if (bus.imem_ack) begin
          req_addr_d = pc_d;
          state_d    = StReq;
        end
      end
      StHold: begin
        if (bus.redirect) begin
          pc_d       = target;
          valid_d    = 1'b0;
          req_addr_d = target;
          state_d    = StReq;
        end else if (bus.instr_ready) begin
          valid_d    = 1'b0;
          req_addr_d = pc_q;
          state_d    = StReq;
        end
      end
      default: state_d = StStart;
    endcase
  end

  assign bus.imem_req    = (state_q == StReq) || (state_q == StDrain);
  assign bus.imem_addr   = req_addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic checked
// against a transaction-level model of the fetch protocol.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if bus ();
  fetch_sequencer_if bus_w ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Second instance exercises the PC wrap from the top of the address space.
  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  assign bus_w.imem_ack    = 1'b1;
  assign bus_w.imem_rdata  = bus_w.imem_addr ^ 32'h5A5A_0000;
  assign bus_w.instr_ready = 1'b1;
  assign bus_w.redirect    = 1'b0;
  assign bus_w.redirect_pc = 32'h0;

  // Model: is a read outstanding, must its data be thrown away, what is held for decode.
  logic        m_pending, m_stale, m_have;
  logic [31:0] m_addr, m_pc, m_instr, m_ipc;
  logic [31:0] seen_addr[$];

  task automatic model_reset();
    m_pending = 1'b0;
    m_stale   = 1'b0;
    m_have    = 1'b0;
    m_addr    = 32'h0;
    m_pc      = 32'h0;
    m_instr   = 32'h0;
    m_ipc     = 32'h0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rd, input logic [31:0] rpc, input logic ack,
                            input logic [31:0] rdata, input logic rdy);
    logic [31:0] tgt;
    tgt = rpc & ~32'd3;
    if (!m_pending) begin
      if (rd) begin
        m_pc = tgt; m_have = 1'b0; m_pending = 1'b1; m_addr = tgt;
      end else if (!m_have || rdy) begin
        m_have = 1'b0; m_pending = 1'b1; m_addr = m_pc;
      end
    end else if (rd) begin
      m_pc = tgt;
      if (ack) begin
        m_addr = tgt; m_stale = 1'b0;
      end else begin
        m_stale = 1'b1;
      end
    end else if (ack) begin
      if (m_stale) begin
        m_addr = m_pc; m_stale = 1'b0;
      end else begin
        m_have = 1'b1; m_instr = rdata; m_ipc = m_addr;
        m_pc = m_addr + 32'd4; m_pending = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", {31'h0, bus.imem_req}, {31'h0, m_pending});
    if (m_pending) chk("imem_addr", bus.imem_addr, m_addr);
    chk("instr_valid", {31'h0, bus.instr_valid}, {31'h0, m_have});
    if (m_have) begin
      chk("instr", bus.instr, m_instr);
      chk("instr_pc", bus.instr_pc, m_ipc);
    end
    chk("pc", bus.pc, m_pc);
  endtask

  task automatic step(input logic rd, input logic [31:0] rpc, input logic ack, input logic rdy);
    logic [31:0] rdata;
    rdata = $urandom;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_ack    = ack;
    bus.imem_rdata  = rdata;
    bus.instr_ready = rdy;
    @(posedge clk);
    #1;
    model_edge(rd, rpc, ack, rdata, rdy);
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, {31'h0, bus.imem_req}, 32'h0);
    chk({tag, "_addr"}, bus.imem_addr, 32'h0);
    chk({tag, "_valid"}, {31'h0, bus.instr_valid}, 32'h0);
    chk({tag, "_instr"}, bus.instr, 32'h0);
    chk({tag, "_instr_pc"}, bus.instr_pc, 32'h0);
    chk({tag, "_pc"}, bus.pc, 32'h0);
  endtask

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    model_reset();
    #1;
    check_reset_values("rst0");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero-wait memory, decode always ready; wrap instance checked alongside.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (bus.imem_req) seen_addr.push_back(bus.imem_addr);
      if (i == 0) begin
        chk("wrap_req0", {31'h0, bus_w.imem_req}, 32'h1);
        chk("wrap_addr0", bus_w.imem_addr, 32'hFFFF_FFFC);
      end
      if (i == 1) begin
        chk("wrap_ipc", bus_w.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc", bus_w.pc, 32'h0);
      end
      if (i == 2) begin
        chk("wrap_req1", {31'h0, bus_w.imem_req}, 32'h1);
        chk("wrap_addr1", bus_w.imem_addr, 32'h0);
      end
    end
    chk("seq_len", seen_addr.size(), 32'd4);
    for (int i = 0; i < 4 && i < seen_addr.size(); i++)
      chk("seq_addr", seen_addr[i], 32'(i * 4));

    // Three wait cycles, then decode stalls four cycles in hold.
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("wait_addr", bus.imem_addr, 32'h10);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("stall_valid", {31'h0, bus.instr_valid}, 32'h1);
      chk("stall_req", {31'h0, bus.imem_req}, 32'h0);
      chk("stall_ipc", bus.instr_pc, 32'h10);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("after_stall_addr", bus.imem_addr, 32'h14);

    // Redirect while the read at 0x14 is outstanding.
    step(1'b1, 32'h0000_0102, 1'b0, 1'b0);
    chk("drain_addr", bus.imem_addr, 32'h14);
    chk("drain_pc", bus.pc, 32'h100);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("drain_novalid", {31'h0, bus.instr_valid}, 32'h0);
    chk("drain_newaddr", bus.imem_addr, 32'h100);

    // Redirect in hold with decode ready in the same cycle.
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("hold_ipc", bus.instr_pc, 32'h100);
    step(1'b1, 32'h0000_2003, 1'b0, 1'b1);
    chk("hold_drop", {31'h0, bus.instr_valid}, 32'h0);
    chk("hold_target", bus.imem_addr, 32'h2000);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) < 6));

    // Reset with a read outstanding and the ack arriving during reset.
    for (int i = 0; i < 10 && !m_pending; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("pre_reset_req", {31'h0, bus.imem_req}, 32'h1);
    bus.redirect   = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = $urandom;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst_async");
    @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    rst = 1'b0;
    model_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("post_reset_addr", bus.imem_addr, 32'h0);
    chk("post_reset_req", {31'h0, bus.imem_req}, 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
